// File: rtl/rs_entry_tracker_pkg.sv
// rs_entry_tracker_pkg: shared reservation-station sizing and entry lifecycle state encoding.
package rs_entry_tracker_pkg;
    localparam int RS_ENTRIES = 8;
    localparam int RS_IDX_W   = $clog2(RS_ENTRIES);
    typedef enum logic [1:0] {RS_FREE, RS_ALLOC, RS_ISSUED} rs_state_e;
endpackage

// File: rtl/rs_free_pick.sv
// rs_free_pick: lowest-index priority encoder over the free-entry vector.
module rs_free_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] free,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (free[i]) idx = W'(i);
        any = |free;
    end
endmodule

// File: rtl/rs_entry_tracker.sv
// rs_entry_tracker: per-entry FREE/ALLOCATED/ISSUED lifecycle for the reservation station.
module rs_entry_tracker
    import rs_entry_tracker_pkg::*;
#(
    parameter int RS_ENTRIES = rs_entry_tracker_pkg::RS_ENTRIES,
    parameter int IDX_W      = $clog2(RS_ENTRIES),
    parameter int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_ready,
    output logic [IDX_W-1:0]      alloc_entry,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_entry,
    input  logic                  retire_rs_valid,
    input  logic [IDX_W-1:0]      retire_rs_entry,
    input  logic                  flush,
    output logic [RS_ENTRIES-1:0] occupied,
    output logic [RS_ENTRIES-1:0] issued,
    output logic [CNT_W-1:0]      free_count,
    output logic                  full,
    output logic                  empty,
    output logic                  proto_err
);
    rs_state_e             state [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] free_vec;
    logic                  alloc_ok, issue_ok, retire_ok, err;

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            free_vec[i] = state[i] == RS_FREE;
            issued[i]   = state[i] == RS_ISSUED;
        end
        occupied = ~free_vec;
    end

    rs_free_pick #(.N(RS_ENTRIES), .W(IDX_W)) u_pick (
        .free (free_vec),
        .idx  (alloc_entry),
        .any  (alloc_ready)
    );

    // Legality is judged on pre-edge state, so legal ops always hit distinct entries.
    assign alloc_ok  = alloc_req && alloc_ready;
    assign issue_ok  = issue_valid && state[issue_entry] == RS_ALLOC;
    assign retire_ok = retire_rs_valid && state[retire_rs_entry] == RS_ISSUED;
    assign err       = (alloc_req && !alloc_ready) || (issue_valid && !issue_ok) ||
                       (retire_rs_valid && !retire_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_ENTRIES; i++) state[i] <= RS_FREE;
            free_count <= CNT_W'(RS_ENTRIES);
            proto_err  <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) state[i] <= RS_FREE;
            free_count <= CNT_W'(RS_ENTRIES);
        end else begin
            if (alloc_ok)  state[alloc_entry]     <= RS_ALLOC;
            if (issue_ok)  state[issue_entry]     <= RS_ISSUED;
            if (retire_ok) state[retire_rs_entry] <= RS_FREE;
            free_count <= free_count + CNT_W'(retire_ok) - CNT_W'(alloc_ok);
            proto_err  <= proto_err | err;
        end
    end

    assign full  = free_count == '0;
    assign empty = free_count == CNT_W'(RS_ENTRIES);

    a_free_count: assert property (@(posedge clk) disable iff (!rst_n)
        free_count == CNT_W'($countones(free_vec)));
endmodule

// File: tb/tb_rs_entry_tracker.sv
// tb_rs_entry_tracker: directed self-checking bench for rs_entry_tracker.
module tb_rs_entry_tracker;
    logic       clk = 0, rst_n = 0;
    logic       alloc_req = 0, issue_valid = 0, retire_rs_valid = 0, flush = 0;
    logic [2:0] issue_entry = 0, retire_rs_entry = 0;
    logic       alloc_ready, full, empty, proto_err;
    logic [2:0] alloc_entry;
    logic [7:0] occupied, issued;
    logic [3:0] free_count;
    int         checks = 0, errors = 0;

    rs_entry_tracker dut (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_entry(alloc_entry), .issue_valid(issue_valid), .issue_entry(issue_entry),
        .retire_rs_valid(retire_rs_valid), .retire_rs_entry(retire_rs_entry), .flush(flush),
        .occupied(occupied), .issued(issued), .free_count(free_count), .full(full),
        .empty(empty), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        alloc_req = 0; issue_valid = 0; retire_rs_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic allocs(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1;
            cycle();
        end
    endtask

    task automatic issue(input logic [2:0] e);
        issue_valid = 1; issue_entry = e;
        cycle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_occ"}, occupied, 8'h00);
        chk({tag, "_iss"}, issued, 8'h00);
        chk({tag, "_fc"}, free_count, 4'd8);
        chk({tag, "_rdy"}, alloc_ready, 1'b1);
        chk({tag, "_ent"}, alloc_entry, 3'd0);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_err"}, proto_err, 1'b0);
    endtask

    initial begin
        #12;
        chk_reset("rst");
        rst_n = 1;
        #4;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("alloc_entry%0d", i), alloc_entry, 32'(i));
            alloc_req = 1;
            cycle();
        end
        chk("fill_full", full, 1'b1);
        chk("fill_rdy", alloc_ready, 1'b0);
        chk("fill_fc", free_count, 4'd0);
        chk("fill_occ", occupied, 8'hff);
        chk("fill_err0", proto_err, 1'b0);
        alloc_req = 1;
        cycle();
        chk("ninth_err", proto_err, 1'b1);
        chk("ninth_fc", free_count, 4'd0);

        do_reset();
        allocs(3);
        issue(3'd1);
        chk("iss1_issued", issued, 8'h02);
        retire_rs_valid = 1; retire_rs_entry = 3'd1;
        cycle();
        chk("ret1_occ", occupied, 8'h05);
        chk("ret1_iss", issued, 8'h00);
        chk("ret1_ent", alloc_entry, 3'd1);
        chk("ret1_fc", free_count, 4'd6);
        chk("ret1_err", proto_err, 1'b0);

        do_reset();
        allocs(8);
        issue(3'd5);
        chk("full_iss5", issued, 8'h20);
        retire_rs_valid = 1; retire_rs_entry = 3'd5; alloc_req = 1;
        cycle();
        chk("rej_err", proto_err, 1'b1);
        chk("rej_ent", alloc_entry, 3'd5);
        chk("rej_fc", free_count, 4'd1);
        chk("rej_occ", occupied, 8'hdf);

        do_reset();
        allocs(4);
        issue_valid = 1; issue_entry = 3'd3; retire_rs_valid = 1; retire_rs_entry = 3'd3;
        cycle();
        chk("ir3_iss", issued, 8'h08);
        chk("ir3_err", proto_err, 1'b1);
        chk("ir3_fc", free_count, 4'd4);

        do_reset();
        allocs(6);
        issue(3'd0);
        issue(3'd1);
        chk("pre_flush_fc", free_count, 4'd2);
        flush = 1; alloc_req = 1; issue_valid = 1; issue_entry = 3'd2;
        retire_rs_valid = 1; retire_rs_entry = 3'd0;
        cycle();
        chk("flush_occ", occupied, 8'h00);
        chk("flush_iss", issued, 8'h00);
        chk("flush_fc", free_count, 4'd8);
        chk("flush_err", proto_err, 1'b0);
        chk("flush_empty", empty, 1'b1);

        do_reset();
        allocs(4);
        for (int i = 0; i < 4; i++) issue(3'(i));
        chk("pre_arst_iss", issued, 8'h0f);
        #2;
        rst_n = 0;
        #1;
        chk_reset("arst");
        #1;
        rst_n = 1;
        allocs(1);
        chk("resume_occ", occupied, 8'h01);
        chk("resume_ent", alloc_entry, 3'd1);
        chk("resume_fc", free_count, 4'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
